psum_accum_sfu: RTL and testbench
=================================

Name: psum_accum_sfu

Overview:
Parametrised successor to the fixed 8-column corelet output stage. Sits between mac_array south outputs and the psum bank controller. Per column, it captures or accumulates partial sums across NUM kernel passes into a DEPTH-entry (len_onij) register store, with saturating signed adds. It then drains one COL-wide output row per handshake, with optional ReLU and ready/valid backpressure. Column reversal, column count, depth and pass count are generalised; the earlier stage hard-coded 8 columns and had no backpressure.

Parameters:
PSUM_BW, 16, signed psum width (input, storage and output)
COL, 8, number of columns
DEPTH, 16, output pixels per column per pass (len_onij)
PASS_W, 4, width of num_passes_i
REVERSE_COLS, 1, 1: input column c maps to internal column COL-1-c

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
start_i  in  1  begin job; sampled only in IDLE
execution_mode  in  1  0 weight-stationary (multi-pass accumulate), 1 output-stationary (single pass, capture only); sampled on start
num_passes_i  in  PASS_W  passes per job in mode 0; 0 treated as 1; sampled on start
relu_en_i  in  1  clamp negatives to 0 on drain; sampled on start
clear_i  in  1  synchronous abort: same effect as reset
in_psum_i  in  COL*PSUM_BW  column psums, column c at [c*PSUM_BW +: PSUM_BW]
in_valid_i  in  COL  per-column valid
out_data_o  out  COL*PSUM_BW  drained row, column order restored
out_valid_o  out  1  row valid
out_ready_i  in  1  consumer ready
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle pulse after last drain handshake
pass_cnt_o  out  PASS_W  completed passes in current job
err_overrun_o  out  1  sticky dropped-psum flag

Behaviour:
- Reset/clear values: state IDLE; all outputs 0; write pointers, read pointer and pass counter 0. Stored data is don't-care; it is never read before being written.
- States: IDLE, ACCUM, DRAIN.
- IDLE -> ACCUM on start_i. Latch mode, passes = (mode ? 1 : max(num_passes_i, 1)) and relu_en.
- ACCUM, column k (after optional reversal): each in_valid bit writes entry wptr[k], then wptr[k]++.
  - First pass (pass_cnt == 0): entry = in.
  - Later passes: entry = sat(entry + in), a signed add saturating to [-2^(PSUM_BW-1), 2^(PSUM_BW-1)-1].
  - Columns advance independently; any number of columns may be valid in the same cycle.
- Pass complete: in the cycle where every wptr equals DEPTH (including the cycle the last write lands), next cycle: all wptr = 0 and pass_cnt++. If pass_cnt+1 == passes, go to DRAIN with rptr = 0.
- Overrun: in_valid on a column with wptr == DEPTH, or in_valid in IDLE or DRAIN. The psum is dropped and err_overrun_o is set; it stays set until reset or clear_i.
- DRAIN:
  - out_valid_o is 1 from the first DRAIN cycle.
  - out_data_o = row rptr, column order restored; with relu, negative values become 0.
  - Data is stable while out_valid_o=1 and out_ready_i=0.
  - Each handshake (valid & ready): rptr++.
  - Handshake on rptr == DEPTH-1: next cycle IDLE, done_o=1 for one cycle, out_valid_o=0, pass_cnt cleared.
- start_i outside IDLE is ignored.
- clear_i or reset in any state takes priority over every other event in that cycle.
- Latency: last input write to first out_valid_o is 2 cycles.

Decomposition:
- Shared package psum_pkg: state enum (IDLE/ACCUM/DRAIN), sat_add function, relu function, column-reverse index function.
- One sub-module, psum_col_store: one column's DEPTH x PSUM_BW store, write pointer, capture/accumulate and saturation logic. Instantiated COL times.
- Top level holds the FSM, pass counter, drain pointer and output mux.

Test Plan:
- Mode 1, DEPTH=16, column c receives value 16c+e at entry e, all columns valid together -> 16 rows out; row e column c = 16c+e; done_o pulses 1 cycle after 16th handshake; err_overrun_o = 0.
- Mode 0, num_passes_i=9, every psum = 3 -> every output = 27. With relu_en=1 and psum = -3 -> every output = 0. pass_cnt_o reaches 9 before DRAIN.
- Saturation, mode 0, 2 passes: 30000 + 30000 -> 32767; -30000 + -30000 -> -32768.
- Skewed columns (column 7 lags 5 cycles), out_ready_i toggled 1/0 -> out_data_o held stable while stalled; rows correct; DRAIN entered only after column 7 fills.
- 17th in_valid on column 0 mid-pass, and in_valid during DRAIN -> dropped; err_overrun_o = 1 and sticky; stored data unaffected.
- clear_i asserted mid-ACCUM (pass 3 of 9), then new start_i -> busy_o = 0 the next cycle; new job's first pass overwrites (stale data not accumulated).

Source files
------------

// File: rtl/psum_pkg.sv
// Shared types and helpers for the psum accumulate / drain stage.
package psum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Signed add of two sign-extended operands, clamped to a bw-bit signed range.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int bw);
        logic signed [63:0] sum;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sum = a + b;
        hi  = (64'sd1 <<< (bw - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (bw - 1));
        if (sum > hi) begin
            sat_add = hi;
        end else if (sum < lo) begin
            sat_add = lo;
        end else begin
            sat_add = sum;
        end
    endfunction

    // Negative values become zero.
    function automatic logic signed [63:0] relu(input logic signed [63:0] a);
        relu = (a < 64'sd0) ? 64'sd0 : a;
    endfunction

    // Column index mapping; the mapping is its own inverse.
    function automatic int rev_idx(input int c, input int n, input bit rev);
        rev_idx = rev ? (n - 1 - c) : c;
    endfunction

endpackage

// File: rtl/psum_col_store.sv
// One column of partial-sum storage: write pointer, capture on the first
// pass, saturating accumulate on later passes, random-access read for drain.
module psum_col_store
    import psum_pkg::*;
#(
    parameter int PSUM_BW = 16,
    parameter int DEPTH   = 16,
    localparam int RP_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int WP_W   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_accum_en,
    input  logic               i_first_pass,
    input  logic               i_pass_done,
    input  logic               i_valid,
    input  logic [PSUM_BW-1:0] i_data,
    input  logic [RP_W-1:0]    i_rd_addr,
    output logic [PSUM_BW-1:0] o_rd_data,
    output logic               o_full,
    output logic               o_overrun
);

    logic [WP_W-1:0]    r_wptr;
    logic [PSUM_BW-1:0] r_mem [DEPTH];

    logic               w_full;
    logic               w_wr;
    logic [RP_W-1:0]    w_waddr;
    logic [PSUM_BW-1:0] w_wdata;

    assign w_full    = (r_wptr == WP_W'(DEPTH));
    assign w_wr      = i_valid && i_accum_en && !w_full;
    assign w_waddr   = r_wptr[RP_W-1:0];
    assign w_wdata   = i_first_pass ? i_data
                     : PSUM_BW'(sat_add(64'(signed'(r_mem[w_waddr])),
                                        64'(signed'(i_data)), PSUM_BW));
    assign o_rd_data = r_mem[i_rd_addr];
    assign o_full    = w_full;
    // A psum arriving outside accumulation, or into a full column, is dropped.
    assign o_overrun = i_valid && (!i_accum_en || w_full);

    // Write pointer: advances per accepted psum, rewinds at each pass boundary.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_wptr <= '0;
        end else if (i_pass_done) begin
            r_wptr <= '0;
        end else if (w_wr) begin
            r_wptr <= r_wptr + WP_W'(1);
        end
    end

    // Storage array: no reset, every entry is written before it is read.
    always_ff @(posedge clk) begin
        if (w_wr && !i_rst) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

endmodule

// File: rtl/psum_accum_sfu.sv
// Output stage between the MAC array and the psum bank: accumulates partial
// sums across kernel passes per column, then drains one row per handshake.
// Handshake: a row transfers on a clock edge where out_valid_o and
// out_ready_i are both 1; out_data_o holds steady while valid and not ready.
module psum_accum_sfu
    import psum_pkg::*;
#(
    parameter int PSUM_BW      = 16,
    parameter int COL          = 8,
    parameter int DEPTH        = 16,
    parameter int PASS_W       = 4,
    parameter bit REVERSE_COLS = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_i,
    input  logic                   execution_mode,
    input  logic [PASS_W-1:0]      num_passes_i,
    input  logic                   relu_en_i,
    input  logic                   clear_i,
    input  logic [COL*PSUM_BW-1:0] in_psum_i,
    input  logic [COL-1:0]         in_valid_i,
    output logic [COL*PSUM_BW-1:0] out_data_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [PASS_W-1:0]      pass_cnt_o,
    output logic                   err_overrun_o
);

    localparam int RP_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [RP_W-1:0] RPTR_LAST = RP_W'(DEPTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PASS_W-1:0]  r_pass_cnt;
    logic [PASS_W-1:0]  r_passes;
    logic [RP_W-1:0]    r_rptr;
    logic               r_relu;
    logic               r_done;
    logic               r_err;

    logic               w_rst;
    logic               w_start;
    logic               w_pass_done;
    logic               w_last_pass;
    logic               w_hs;
    logic               w_last_hs;
    logic               w_accum_en;
    logic               w_first_pass;
    logic [COL-1:0]     w_full;
    logic [COL-1:0]     w_ovr;
    logic [PSUM_BW-1:0] w_rd [COL];

    assign w_rst        = reset || clear_i;
    assign w_accum_en   = (r_state == ST_ACCUM);
    assign w_first_pass = (r_pass_cnt == '0);
    assign w_last_pass  = (({1'b0, r_pass_cnt} + (PASS_W + 1)'(1)) == {1'b0, r_passes});

    // Internal column k is fed from input column rev_idx(k).
    for (genvar k = 0; k < COL; k++) begin : g_col
        localparam int SRC = rev_idx(k, COL, REVERSE_COLS);
        psum_col_store #(
            .PSUM_BW (PSUM_BW),
            .DEPTH   (DEPTH)
        ) u_store (
            .clk          (clk),
            .i_rst        (w_rst),
            .i_accum_en   (w_accum_en),
            .i_first_pass (w_first_pass),
            .i_pass_done  (w_pass_done),
            .i_valid      (in_valid_i[SRC]),
            .i_data       (in_psum_i[SRC*PSUM_BW +: PSUM_BW]),
            .i_rd_addr    (r_rptr),
            .o_rd_data    (w_rd[k]),
            .o_full       (w_full[k]),
            .o_overrun    (w_ovr[k])
        );
    end

    // Output column c comes back from internal column rev_idx(c).
    for (genvar c = 0; c < COL; c++) begin : g_out
        localparam int K = rev_idx(c, COL, REVERSE_COLS);
        assign out_data_o[c*PSUM_BW +: PSUM_BW] =
            (r_state != ST_DRAIN) ? '0
            : r_relu ? PSUM_BW'(relu(64'(signed'(w_rd[K]))))
            : w_rd[K];
    end

    assign out_valid_o   = (r_state == ST_DRAIN);
    assign busy_o        = (r_state != ST_IDLE);
    assign done_o        = r_done;
    assign pass_cnt_o    = r_pass_cnt;
    assign err_overrun_o = r_err;

    // State register.
    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus the per-cycle events that drive the datapath registers.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_pass_done = 1'b0;
        w_hs        = 1'b0;
        w_last_hs   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (&w_full) begin
                    w_pass_done = 1'b1;
                    if (w_last_pass) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                w_hs = out_ready_i;
                if (out_ready_i && (r_rptr == RPTR_LAST)) begin
                    w_last_hs   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Job configuration, pass counter, drain pointer, done pulse, sticky error.
    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_passes   <= '0;
            r_relu     <= 1'b0;
            r_pass_cnt <= '0;
            r_rptr     <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= w_last_hs;
            if (|w_ovr) begin
                r_err <= 1'b1;
            end
            if (w_start) begin
                r_passes <= (execution_mode || (num_passes_i == '0)) ? PASS_W'(1) : num_passes_i;
                r_relu   <= relu_en_i;
            end
            if (w_pass_done) begin
                r_pass_cnt <= r_pass_cnt + PASS_W'(1);
            end else if (w_last_hs) begin
                r_pass_cnt <= '0;
            end
            if (w_pass_done) begin
                r_rptr <= '0;
            end else if (w_hs) begin
                r_rptr <= r_rptr + RP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_psum_accum_sfu.sv
// Bench for psum_accum_sfu: scenario tasks push expected rows into a queue
// as stimulus is driven; the drain loop pops and compares each accepted row.
module tb_psum_accum_sfu;

    localparam int PSUM_BW = 16;
    localparam int COL     = 8;
    localparam int DEPTH   = 16;
    localparam int PASS_W  = 4;
    localparam int W       = COL * PSUM_BW;

    logic              clk = 1'b0;
    logic              reset;
    logic              start_i;
    logic              execution_mode;
    logic [PASS_W-1:0] num_passes_i;
    logic              relu_en_i;
    logic              clear_i;
    logic [W-1:0]      in_psum_i;
    logic [COL-1:0]    in_valid_i;
    logic [W-1:0]      out_data_o;
    logic              out_valid_o;
    logic              out_ready_i;
    logic              busy_o;
    logic              done_o;
    logic [PASS_W-1:0] pass_cnt_o;
    logic              err_overrun_o;

    logic [W-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    psum_accum_sfu #(
        .PSUM_BW      (PSUM_BW),
        .COL          (COL),
        .DEPTH        (DEPTH),
        .PASS_W       (PASS_W),
        .REVERSE_COLS (1'b1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start_i        (start_i),
        .execution_mode (execution_mode),
        .num_passes_i   (num_passes_i),
        .relu_en_i      (relu_en_i),
        .clear_i        (clear_i),
        .in_psum_i      (in_psum_i),
        .in_valid_i     (in_valid_i),
        .out_data_o     (out_data_o),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .pass_cnt_o     (pass_cnt_o),
        .err_overrun_o  (err_overrun_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- model helpers ----------------
    function automatic logic [W-1:0] pack_const(input logic [PSUM_BW-1:0] v);
        logic [W-1:0] r;
        for (int c = 0; c < COL; c++) r[c*PSUM_BW +: PSUM_BW] = v;
        return r;
    endfunction

    function automatic logic [PSUM_BW-1:0] sat16(input int a);
        if (a > 32767) return 16'h7fff;
        if (a < -32768) return 16'h8000;
        return a[15:0];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_start(input logic mode, input logic [PASS_W-1:0] np, input logic relu);
        execution_mode = mode;
        num_passes_i   = np;
        relu_en_i      = relu;
        start_i        = 1'b1;
        tick();
        start_i        = 1'b0;
    endtask

    // One full pass of identical rows, then the idle pass-boundary cycle.
    task automatic drive_row_pass(input logic [W-1:0] row);
        in_psum_i  = row;
        in_valid_i = '1;
        repeat (DEPTH) tick();
        in_valid_i = '0;
        tick();
    endtask

    // rmode: 0 always ready, 1 toggling, 2 random. Pops and compares every
    // accepted row, checks hold-while-stalled, then the done pulse.
    task automatic drain_check(input int n_rows, input int rmode);
        int got = 0;
        int cyc = 0;
        logic stalled = 1'b0;
        logic [W-1:0] held = '0;
        logic [W-1:0] exp_row;
        while (got < n_rows && cyc < 400) begin
            case (rmode)
                0:       out_ready_i = 1'b1;
                1:       out_ready_i = (cyc % 2 == 0);
                default: out_ready_i = 1'($urandom_range(0, 1));
            endcase
            if (stalled) begin
                n_tests++;
                if (out_data_o !== held) begin
                    n_fail++;
                    $display("FAIL hold_stable: got %h expected %h", out_data_o, held);
                end
            end
            if (out_valid_o && out_ready_i) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_underflow: got row %h expected no row", out_data_o);
                end else begin
                    exp_row = exp_q.pop_front();
                    if (out_data_o !== exp_row) begin
                        n_fail++;
                        $display("FAIL row%0d: got %h expected %h", got, out_data_o, exp_row);
                    end
                end
                got++;
            end
            stalled = out_valid_o && !out_ready_i;
            held    = out_data_o;
            tick();
            cyc++;
        end
        out_ready_i = 1'b0;
        n_tests++;
        if (got != n_rows) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d rows expected %0d", got, n_rows);
        end
        n_tests++;
        if ({done_o, out_valid_o, busy_o, pass_cnt_o} !== {1'b1, 1'b0, 1'b0, {PASS_W{1'b0}}}) begin
            n_fail++;
            $display("FAIL done_state: got done=%b valid=%b busy=%b pass=%0d expected 1 0 0 0",
                     done_o, out_valid_o, busy_o, pass_cnt_o);
        end
        tick();
        n_tests++;
        if (done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse: got %b expected 0", done_o);
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d rows left expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; start_i = 1'b0; execution_mode = 1'b0; num_passes_i = '0;
        relu_en_i = 1'b0; clear_i = 1'b0; in_psum_i = '0; in_valid_i = '0; out_ready_i = 1'b0;
        repeat (3) tick();
        n_tests++;
        if ({busy_o, out_valid_o, done_o, err_overrun_o, pass_cnt_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0", {busy_o, out_valid_o, done_o, err_overrun_o, pass_cnt_o});
        end
        n_tests++;
        if (out_data_o !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 0", out_data_o);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_os_mode();
        logic [W-1:0] row;
        do_start(1'b1, 4'd0, 1'b0);
        in_valid_i = '1;
        for (int e = 0; e < DEPTH; e++) begin
            for (int c = 0; c < COL; c++) row[c*PSUM_BW +: PSUM_BW] = PSUM_BW'(16 * c + e);
            exp_q.push_back(row);
            in_psum_i = row;
            tick();
        end
        in_valid_i = '0;
        n_tests++;
        if (out_valid_o !== 1'b0 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL os_latency1: got valid=%b busy=%b expected 0 1", out_valid_o, busy_o);
        end
        tick();
        n_tests++;
        if (out_valid_o !== 1'b1 || pass_cnt_o !== 4'd1) begin
            n_fail++;
            $display("FAIL os_latency2: got valid=%b pass=%0d expected 1 1", out_valid_o, pass_cnt_o);
        end
        drain_check(DEPTH, 0);
        n_tests++;
        if (err_overrun_o !== 1'b0) begin
            n_fail++;
            $display("FAIL os_err: got %b expected 0", err_overrun_o);
        end
    endtask

    task automatic test_multipass();
        logic [W-1:0] row;
        do_start(1'b0, 4'd9, 1'b0);
        for (int p = 0; p < 9; p++) begin
            drive_row_pass(pack_const(16'd3));
            if (p == 7) begin
                n_tests++;
                if (pass_cnt_o !== 4'd8 || out_valid_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL mp_pass8: got pass=%0d valid=%b expected 8 0", pass_cnt_o, out_valid_o);
                end
            end
        end
        n_tests++;
        if (pass_cnt_o !== 4'd9 || out_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL mp_pass9: got pass=%0d valid=%b expected 9 1", pass_cnt_o, out_valid_o);
        end
        repeat (DEPTH) exp_q.push_back(pack_const(16'd27));
        drain_check(DEPTH, 0);
        // ReLU: negative columns clamp to 0, positive columns pass through.
        do_start(1'b0, 4'd3, 1'b1);
        for (int c = 0; c < COL; c++) row[c*PSUM_BW +: PSUM_BW] = (c % 2 == 0) ? -16'sd3 : 16'sd3;
        repeat (3) drive_row_pass(row);
        for (int c = 0; c < COL; c++) row[c*PSUM_BW +: PSUM_BW] = (c % 2 == 0) ? 16'd0 : 16'd9;
        repeat (DEPTH) exp_q.push_back(row);
        drain_check(DEPTH, 1);
    endtask

    task automatic test_saturation();
        int v [4] = '{30000, -30000, 1000, -5};
        logic [W-1:0] row_in;
        logic [W-1:0] row_exp;
        for (int c = 0; c < COL; c++) begin
            row_in[c*PSUM_BW +: PSUM_BW]  = v[c % 4][15:0];
            row_exp[c*PSUM_BW +: PSUM_BW] = sat16(2 * v[c % 4]);
        end
        do_start(1'b0, 4'd2, 1'b0);
        repeat (2) drive_row_pass(row_in);
        repeat (DEPTH) exp_q.push_back(row_exp);
        drain_check(DEPTH, 2);
    endtask

    task automatic test_zero_passes();
        logic [W-1:0] row;
        for (int c = 0; c < COL; c++) row[c*PSUM_BW +: PSUM_BW] = PSUM_BW'(100 + c);
        do_start(1'b0, 4'd0, 1'b0);
        drive_row_pass(row);
        n_tests++;
        if (pass_cnt_o !== 4'd1 || out_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_passes: got pass=%0d valid=%b expected 1 1", pass_cnt_o, out_valid_o);
        end
        repeat (DEPTH) exp_q.push_back(row);
        drain_check(DEPTH, 0);
    endtask

    // Column 7 lags 5 cycles; a stray start during ACCUM must be ignored.
    task automatic test_skew_backpressure();
        logic [PSUM_BW-1:0] vals [DEPTH][COL];
        logic [W-1:0] row;
        for (int e = 0; e < DEPTH; e++) begin
            for (int c = 0; c < COL; c++) begin
                vals[e][c] = PSUM_BW'($urandom_range(0, 65535));
                row[c*PSUM_BW +: PSUM_BW] = vals[e][c];
            end
            exp_q.push_back(row);
        end
        do_start(1'b1, 4'd0, 1'b0);
        for (int t = 0; t < DEPTH + 5; t++) begin
            if (t >= DEPTH) begin
                n_tests++;
                if (out_valid_o !== 1'b0 || busy_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL skew_wait t=%0d: got valid=%b busy=%b expected 0 1", t, out_valid_o, busy_o);
                end
            end
            in_valid_i = '0;
            in_psum_i  = '0;
            for (int c = 0; c < COL - 1; c++) begin
                if (t < DEPTH) begin
                    in_valid_i[c] = 1'b1;
                    in_psum_i[c*PSUM_BW +: PSUM_BW] = vals[t][c];
                end
            end
            if (t >= 5) begin
                in_valid_i[COL-1] = 1'b1;
                in_psum_i[(COL-1)*PSUM_BW +: PSUM_BW] = vals[t-5][COL-1];
            end
            start_i        = (t == 10);
            execution_mode = 1'b0;
            num_passes_i   = 4'd9;
            tick();
        end
        start_i    = 1'b0;
        in_valid_i = '0;
        tick();
        n_tests++;
        if (out_valid_o !== 1'b1 || pass_cnt_o !== 4'd1) begin
            n_fail++;
            $display("FAIL skew_drain_entry: got valid=%b pass=%0d expected 1 1", out_valid_o, pass_cnt_o);
        end
        drain_check(DEPTH, 1);
    endtask

    task automatic test_overrun();
        logic [W-1:0] row;
        do_start(1'b1, 4'd0, 1'b0);
        n_tests++;
        if (err_overrun_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_pre: got %b expected 0", err_overrun_o);
        end
        for (int e = 0; e < DEPTH; e++) begin
            for (int c = 0; c < COL; c++) row[c*PSUM_BW +: PSUM_BW] = PSUM_BW'(1000 + 16 * c + e);
            exp_q.push_back(row);
        end
        // Column 0 gets 17 valids; columns 1..7 lag by 2 so the pass is still open.
        for (int t = 0; t < DEPTH + 2; t++) begin
            in_valid_i = '0;
            in_psum_i  = '0;
            if (t <= DEPTH) begin
                in_valid_i[0] = 1'b1;
                in_psum_i[0 +: PSUM_BW] = (t < DEPTH) ? PSUM_BW'(1000 + t) : 16'h7fff;
            end
            for (int c = 1; c < COL; c++) begin
                if (t >= 2) begin
                    in_valid_i[c] = 1'b1;
                    in_psum_i[c*PSUM_BW +: PSUM_BW] = PSUM_BW'(1000 + 16 * c + t - 2);
                end
            end
            tick();
        end
        in_valid_i = '0;
        n_tests++;
        if (err_overrun_o !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_17th: got %b expected 1", err_overrun_o);
        end
        tick();
        n_tests++;
        if (out_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_drain_entry: got %b expected 1", out_valid_o);
        end
        in_valid_i  = '1;
        in_psum_i   = pack_const(16'h5555);
        out_ready_i = 1'b0;
        tick();
        in_valid_i = '0;
        drain_check(DEPTH, 0);
        n_tests++;
        if (err_overrun_o !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_sticky: got %b expected 1", err_overrun_o);
        end
    endtask

    task automatic test_clear();
        do_start(1'b0, 4'd9, 1'b0);
        repeat (2) drive_row_pass(pack_const(16'd5));
        in_psum_i  = pack_const(16'd5);
        in_valid_i = '1;
        repeat (7) tick();
        n_tests++;
        if (pass_cnt_o !== 4'd2 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_pre: got pass=%0d busy=%b expected 2 1", pass_cnt_o, busy_o);
        end
        clear_i = 1'b1;
        tick();
        clear_i    = 1'b0;
        in_valid_i = '0;
        n_tests++;
        if ({busy_o, out_valid_o, err_overrun_o, pass_cnt_o} !== '0) begin
            n_fail++;
            $display("FAIL clr_state: got %b expected 0", {busy_o, out_valid_o, err_overrun_o, pass_cnt_o});
        end
        do_start(1'b0, 4'd2, 1'b0);
        repeat (2) drive_row_pass(pack_const(16'd7));
        repeat (DEPTH) exp_q.push_back(pack_const(16'd14));
        drain_check(DEPTH, 2);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_os_mode();
        test_multipass();
        test_saturation();
        test_zero_passes();
        test_skew_backpressure();
        test_overrun();
        test_clear();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
